imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 152 +++++++++++++++
 tb/tb_imm_extend_pipe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_extend_pipe
// Purpose  : Decodes and sign/zero-extends a RISC-V immediate, then queues
//            the result in a 2-entry FIFO with a valid/ready handshake on
//            both sides.
// Ports    : clk, rst_n              - clock, async active-low reset
//            in_valid / in_ready     - request handshake (instr, immsrc)
//            instr[24:0]             - instruction bits [31:7]
//            immsrc[2:0]             - 000 I, 001 S, 010 B, 011 J, 100 U,
//                                      101 zimm, 110/111 illegal
//            out_valid / out_ready   - result handshake (immext, illegal)
//            immext[XLEN-1:0]        - extended immediate at FIFO head
//            illegal                 - head entry came from an illegal immsrc
//            err_seen                - sticky: an illegal request was accepted
// Revision : 1.0 - initial release
// ============================================================================
module imm_extend_pipe #(
  parameter int XLEN    = 32,
  parameter int ZIMM_EN = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [24:0]     instr,
  input  logic [2:0]      immsrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] immext,
  output logic            illegal,
  output logic            err_seen
);

  // Immediate format encodings
  localparam logic [2:0] c_SRC_I = 3'b000;
  localparam logic [2:0] c_SRC_S = 3'b001;
  localparam logic [2:0] c_SRC_B = 3'b010;
  localparam logic [2:0] c_SRC_J = 3'b011;
  localparam logic [2:0] c_SRC_U = 3'b100;
  localparam logic [2:0] c_SRC_Z = 3'b101;

  // Occupancy states; the state register doubles as the entry count
  localparam logic [1:0] c_EMPTY = 2'd0;
  localparam logic [1:0] c_ONE   = 2'd1;
  localparam logic [1:0] c_FULL  = 2'd2;

  logic [31:0]     w_imm32;
  logic            w_ill;
  logic [XLEN-1:0] w_imm_ext;
  logic            w_accept;
  logic            w_consume;

  logic [1:0]      r_count;
  logic            r_wptr;
  logic            r_rptr;
  logic [XLEN-1:0] r_mem_imm [2];
  logic [1:0]      r_mem_ill;
  logic            r_err_seen;

  // --------------------------------------------------------------------------
  // Immediate decode. instr holds full-instruction bits [31:7], so a full
  // bit k lives at instr[k-7]. Every format is built as a 32-bit value whose
  // bit 31 is the correct fill bit: zimm and illegal have bit 31 clear, so a
  // single sign extension to XLEN serves all formats.
  // --------------------------------------------------------------------------
  always_comb begin
    w_imm32 = 32'd0;
    w_ill   = 1'b0;
    case (immsrc)
      c_SRC_I: w_imm32 = {{20{instr[24]}}, instr[24:13]};
      c_SRC_S: w_imm32 = {{20{instr[24]}}, instr[24:18], instr[4:0]};
      c_SRC_B: w_imm32 = {{19{instr[24]}}, instr[24], instr[0],
                          instr[23:18], instr[4:1], 1'b0};
      c_SRC_J: w_imm32 = {{11{instr[24]}}, instr[24], instr[12:5],
                          instr[13], instr[23:14], 1'b0};
      c_SRC_U: w_imm32 = {instr[24:5], 12'd0};
      c_SRC_Z: begin
        if (ZIMM_EN != 0) begin
          w_imm32 = {27'd0, instr[12:8]};
        end else begin
          w_ill = 1'b1;
        end
      end
      default: w_ill = 1'b1;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_xlen_wide
      assign w_imm_ext = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else begin : g_xlen_32
      assign w_imm_ext = w_imm32;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Handshake. in_ready comes from the registered count only, so it never
  // depends combinationally on out_ready.
  // --------------------------------------------------------------------------
  assign in_ready  = (r_count != c_FULL);
  assign out_valid = (r_count != c_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_consume = out_valid & out_ready;

  // --------------------------------------------------------------------------
  // FIFO storage, pointers and occupancy. With one entry stored, a write and
  // a read in the same edge move the read pointer onto the slot just
  // written, so the new result becomes the head without a bubble.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= c_EMPTY;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
      r_mem_imm[0] <= '0;
      r_mem_imm[1] <= '0;
      r_mem_ill    <= 2'b00;
      r_err_seen   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mem_imm[r_wptr] <= w_imm_ext;
        r_mem_ill[r_wptr] <= w_ill;
        r_wptr            <= ~r_wptr;
        if (w_ill) begin
          r_err_seen <= 1'b1;
        end
      end
      if (w_consume) begin
        r_rptr <= ~r_rptr;
      end
      case (r_count)
        c_EMPTY: if (w_accept) r_count <= c_ONE;
        c_ONE: begin
          if (w_accept && !w_consume) begin
            r_count <= c_FULL;
          end else if (!w_accept && w_consume) begin
            r_count <= c_EMPTY;
          end
        end
        c_FULL:  if (w_consume) r_count <= c_ONE;
        default: r_count <= c_EMPTY;
      endcase
    end
  end

  assign immext   = r_mem_imm[r_rptr];
  assign illegal  = r_mem_ill[r_rptr];
  assign err_seen = r_err_seen;

endmodule
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_extend_pipe
// Purpose  : Directed self-checking bench for imm_extend_pipe. Three
//            instances share stimulus: XLEN=32/ZIMM_EN=1 (main), XLEN=64,
//            and XLEN=32/ZIMM_EN=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [24:0] instr;
  logic [2:0]  immsrc;

  logic        in_ready,  out_valid,  illegal,  err_seen;
  logic [31:0] immext;
  logic        in_ready_w, out_valid_w, illegal_w, err_seen_w;
  logic [63:0] immext_w;
  logic        in_ready_z, out_valid_z, illegal_z, err_seen_z;
  logic [31:0] immext_z;

  int checks = 0;
  int errors = 0;

  imm_extend_pipe #(.XLEN(32), .ZIMM_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .immsrc(immsrc), .out_valid(out_valid),
    .out_ready(out_ready), .immext(immext), .illegal(illegal),
    .err_seen(err_seen)
  );

  imm_extend_pipe #(.XLEN(64), .ZIMM_EN(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .instr(instr), .immsrc(immsrc), .out_valid(out_valid_w),
    .out_ready(out_ready), .immext(immext_w), .illegal(illegal_w),
    .err_seen(err_seen_w)
  );

  imm_extend_pipe #(.XLEN(32), .ZIMM_EN(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
    .instr(instr), .immsrc(immsrc), .out_valid(out_valid_z),
    .out_ready(out_ready), .immext(immext_z), .illegal(illegal_z),
    .err_seen(err_seen_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; immsrc = '0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (immext !== 32'h0) begin errors++; $display("FAIL reset_immext got %h exp 00000000", immext); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL reset_err_seen got %b exp 0", err_seen); end
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got %b exp 0", out_valid); end
  endtask

  task automatic test_formats();
    logic [24:0] v_instr [8];
    logic [2:0]  v_src   [8];
    logic [31:0] v_e32   [8];
    logic [63:0] v_e64   [8];
    // I, S, B, J, U, zimm, U negative, I all-ones
    v_instr[0] = 25'b1111000011110000111000110; v_src[0] = 3'b000; v_e32[0] = 32'hFFFFFF0F; v_e64[0] = 64'hFFFFFFFFFFFFFF0F;
    v_instr[1] = 25'h0040002;                   v_src[1] = 3'b001; v_e32[1] = 32'h00000022; v_e64[1] = 64'h0000000000000022;
    v_instr[2] = 25'h1000002;                   v_src[2] = 3'b010; v_e32[2] = 32'hFFFFF002; v_e64[2] = 64'hFFFFFFFFFFFFF002;
    v_instr[3] = 25'h0000020;                   v_src[3] = 3'b011; v_e32[3] = 32'h00001000; v_e64[3] = 64'h0000000000001000;
    v_instr[4] = 25'h02468A0;                   v_src[4] = 3'b100; v_e32[4] = 32'h12345000; v_e64[4] = 64'h0000000012345000;
    v_instr[5] = 25'h0001500;                   v_src[5] = 3'b101; v_e32[5] = 32'h00000015; v_e64[5] = 64'h0000000000000015;
    v_instr[6] = 25'h1000000;                   v_src[6] = 3'b100; v_e32[6] = 32'h80000000; v_e64[6] = 64'hFFFFFFFF80000000;
    v_instr[7] = 25'h1FFFFFF;                   v_src[7] = 3'b000; v_e32[7] = 32'hFFFFFFFF; v_e64[7] = 64'hFFFFFFFFFFFFFFFF;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fmt%0d_in_ready got %b exp 1", i, in_ready); end
      instr = v_instr[i]; immsrc = v_src[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fmt%0d_out_valid got %b exp 1", i, out_valid); end
      checks++; if (immext !== v_e32[i]) begin errors++; $display("FAIL fmt%0d_immext32 got %h exp %h", i, immext, v_e32[i]); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL fmt%0d_illegal got %b exp 0", i, illegal); end
      checks++; if (immext_w !== v_e64[i]) begin errors++; $display("FAIL fmt%0d_immext64 got %h exp %h", i, immext_w, v_e64[i]); end
      checks++; if (illegal_z !== (i == 5)) begin errors++; $display("FAIL fmt%0d_illegal_nozimm got %b exp %b", i, illegal_z, (i == 5)); end
      checks++; if (immext_z !== ((i == 5) ? 32'h0 : v_e32[i])) begin errors++; $display("FAIL fmt%0d_immext_nozimm got %h exp %h", i, immext_z, ((i == 5) ? 32'h0 : v_e32[i])); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fmt%0d_drained got %b exp 0", i, out_valid); end
    end
    checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL fmt_err_seen got %b exp 0", err_seen); end
    checks++; if (err_seen_z !== 1'b1) begin errors++; $display("FAIL fmt_err_seen_nozimm got %b exp 1", err_seen_z); end
  endtask

  task automatic test_illegal();
    checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL ill_err_seen_before got %b exp 0", err_seen); end
    out_ready = 1'b1;
    for (int s = 6; s < 8; s++) begin
      instr = 25'h1FFFFFF; immsrc = 3'(s); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ill%0d_out_valid got %b exp 1", s, out_valid); end
      checks++; if (immext !== 32'h0) begin errors++; $display("FAIL ill%0d_immext got %h exp 00000000", s, immext); end
      checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill%0d_illegal got %b exp 1", s, illegal); end
      checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL ill%0d_err_seen got %b exp 1", s, err_seen); end
      checks++; if (immext_w !== 64'h0) begin errors++; $display("FAIL ill%0d_immext64 got %h exp 0", s, immext_w); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ill%0d_drained got %b exp 0", s, out_valid); end
      checks++; if (err_seen !== 1'b1) begin errors++; $display("FAIL ill%0d_err_sticky got %b exp 1", s, err_seen); end
    end
  endtask

  task automatic test_back_to_back();
    // Three I-format requests with immediates 1, 2, 3 under backpressure
    out_ready = 1'b0; immsrc = 3'b000;
    instr = 25'h0002000; in_valid = 1'b1;
    tick();
    checks++; if (immext !== 32'd1 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_first got v=%b imm=%h exp v=1 imm=00000001", out_valid, immext); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_one_in_ready got %b exp 1", in_ready); end
    instr = 25'h0004000;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_in_ready got %b exp 0", in_ready); end
    checks++; if (immext !== 32'd1) begin errors++; $display("FAIL b2b_head_hold1 got %h exp 00000001", immext); end
    instr = 25'h0006000;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready got %b exp 0", in_ready); end
    checks++; if (immext !== 32'd1 || illegal !== 1'b0) begin errors++; $display("FAIL b2b_head_hold2 got imm=%h ill=%b exp imm=00000001 ill=0", immext, illegal); end
    out_ready = 1'b1;
    tick();
    checks++; if (immext !== 32'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_second got v=%b imm=%h exp v=1 imm=00000002", out_valid, immext); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_freed_in_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (immext !== 32'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_third got v=%b imm=%h exp v=1 imm=00000003", out_valid, immext); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 25'h000A000; immsrc = 3'b000;
    tick();
    instr = 25'h1FFFFFF; immsrc = 3'b110;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_full got %b exp 0", in_ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b exp 0", out_valid); end
    checks++; if (err_seen !== 1'b0) begin errors++; $display("FAIL rmid_err_seen got %b exp 0", err_seen); end
    checks++; if (immext !== 32'h0 || illegal !== 1'b0) begin errors++; $display("FAIL rmid_outputs got imm=%h ill=%b exp 0 0", immext, illegal); end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_stale%0d got %b exp 0", c, out_valid); end
    end
    instr = 25'h02468A0; immsrc = 3'b100; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || immext !== 32'h12345000) begin errors++; $display("FAIL rmid_resume got v=%b imm=%h exp v=1 imm=12345000", out_valid, immext); end
    tick();
  endtask

  initial begin
    test_reset();
    test_formats();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
